// File: rtl/divider_if.sv
// Operand/result bundle between the issue logic and the iterative divider.
// The master drives the request; the slave returns the registered result and the ready pulse.
interface divider_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/divider.sv
// Restoring radix-2 32-bit DIV/DIVU unit: 33-cycle latency, result {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor through DZERO (2-cycle latency, result 0).
module divider (
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
`ifdef DIV_ZERO_FAST_EN
    localparam logic [1:0] DZERO = 2'd3;
`endif

    logic [1:0]  state;
    logic [5:0]  count;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] result_r;
    logic        ready_r;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Magnitudes of the signed operands; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign mag1 = (bus.signed_div && bus.opdata1[31]) ? (~bus.opdata1 + 32'd1) : bus.opdata1;
    assign mag2 = (bus.signed_div && bus.opdata2[31]) ? (~bus.opdata2 + 32'd1) : bus.opdata2;

    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, dvs};
    assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_next = {quo[30:0], ~diff[32]};

    assign q_fix = neg_q ? (~quo_next + 32'd1) : quo_next;
    assign r_fix = neg_r ? (~rem_next + 32'd1) : rem_next;

    assign bus.result = result_r;
    assign bus.ready  = ready_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_r <= 64'd0;
            ready_r  <= 1'b0;
        end else if (bus.annul) begin
            state   <= IDLE;
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem   <= 32'd0;
                        quo   <= mag1;
                        dvs   <= mag2;
                        neg_q <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
                        neg_r <= bus.signed_div & bus.opdata1[31];
                        count <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.opdata2 == 32'd0)
                            state <= DZERO;
                        else
                            state <= BUSY;
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 6'd1;
                    // The 32nd step writes the fixed-up result directly so ready and result land together.
                    if (count == 6'd31) begin
                        state    <= DONE;
                        ready_r  <= 1'b1;
                        result_r <= {r_fix, q_fix};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef DIV_ZERO_FAST_EN
                DZERO: begin
                    state    <= DONE;
                    ready_r  <= 1'b1;
                    result_r <= 64'd0;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, randomized ops against an
// arithmetic reference model, plus annul and mid-operation reset sequences.
module tb_divider;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    divider_if bus ();

    divider dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_result;
        int          exp_lat;
    } vec_t;

    // Architectural meaning of DIV/DIVU, including the defined divide-by-zero behaviour.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 64'd0;
`endif
        if (!sd) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
        end
        if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one divide with start held until ready, scrambling operands while busy.
    task automatic applyStimulus(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [63:0] res);
        lat = -1;
        res = 'x;
        @(negedge clk);
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = ~sd;
            end
            if (bus.ready) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_one_cycle", {63'd0, bus.ready}, 64'd0);
    endtask

    task automatic runOne(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_result, input int exp_lat);
        int          lat;
        logic [63:0] res;
        applyStimulus(sd, a, b, lat, res);
        checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, "_result"}, res, exp_result);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [63:0] prior;
        logic [63:0] expect_res;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsd;

        checks = 0;
        errors = 0;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2,         32'd14},        33});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,         32'hFFFF_FFFD}, 33});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,         32'h8000_0000}, 33});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,         32'hFFFF_FFFF}, 33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0,         32'h1},         33});
        vecs.push_back('{1'b0, 32'h1234_5678,  32'h100,        {32'h78,        32'h0012_3456}, 33});
        vecs.push_back('{1'b0, 32'd0,          32'd5,          {32'd0,         32'd0},         33});
`ifdef DIV_ZERO_FAST_EN
        vecs.push_back('{1'b0, 32'd5,          32'd0,          64'd0,                          2});
`else
        vecs.push_back('{1'b0, 32'd5,          32'd0,          {32'd5,         32'hFFFF_FFFF}, 33});
`endif

        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd0;
        bus.opdata2    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, bus.ready}, 64'd0);
        checkOutput("reset_result", bus.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        $display("[TB] directed vectors");
        foreach (vecs[i])
            runOne($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp_result, vecs[i].exp_lat);

        $display("[TB] random vectors");
        for (int n = 0; n < 40; n++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            runOne($sformatf("rand%0d", n), rsd, ra, rb, ref_div(rsd, ra, rb), ref_lat(rb));
        end

        // Annul mid-divide, with start still held: annul must also block a restart in the IDLE cycle.
        $display("[TB] annul sequence");
        runOne("prior", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        prior      = {32'd2, 32'd14};
        expect_res = ref_div(1'b0, 32'd1000, 32'd3);
        @(negedge clk);
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        bus.start      = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            @(posedge clk);
            #1;
            bus.annul = (c == 10 || c == 11);
            checkOutput($sformatf("annul_ready_c%0d", c), {63'd0, bus.ready}, (c == 45) ? 64'd1 : 64'd0);
            checkOutput($sformatf("annul_result_c%0d", c), bus.result, (c >= 45) ? expect_res : prior);
            if (c == 45) bus.start = 1'b0;
        end
        bus.annul = 1'b0;

        // Reset during a divide, with start held across the reset cycles.
        $display("[TB] mid-operation reset sequence");
        @(negedge clk);
        bus.opdata1 = 32'd77;
        bus.opdata2 = 32'd5;
        bus.start   = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) resetn = 1'b0;
            if (c == 22) begin
                resetn    = 1'b1;
                bus.start = 1'b0;
            end
            if (c >= 21) begin
                checkOutput($sformatf("rst_ready_c%0d", c), {63'd0, bus.ready}, 64'd0);
                checkOutput($sformatf("rst_result_c%0d", c), bus.result, 64'd0);
            end
        end
        bus.start = 1'b0;

        runOne("after_reset", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: resetn  in  1  synchronous active-low reset; sampled on rising clk edge only.
REQ-003 SHALL have ports: signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-004 SHALL have ports: opdata1  in  32  dividend; sampled with start.
REQ-005 SHALL have ports: opdata2  in  32  divisor; sampled with start.
REQ-006 SHALL have ports: start  in  1  request from hazard unit; held high until ready is seen.
REQ-007 SHALL have ports: annul  in  1  exception/flush abort; synchronous.
REQ-008 SHALL have ports: result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-009 SHALL have ports: ready  out  1  registered one-cycle completion pulse.
REQ-010 SHALL have: one clock; reset synchronous and active-low, ports named clk and resetn.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE, plus DZERO when DIV_ZERO_FAST_EN is defined.
REQ-012 SHALL, in IDLE with start=1 and annul=0 at cycle N: latch operand magnitudes and sign flags, clear the 6-bit iteration counter, and enter BUSY at N+1.
REQ-013 SHALL, when signed_div=1, use operand magnitudes (|x|) for iteration; when signed_div=0, use operands unmodified.
REQ-014 SHALL perform one restoring radix-2 step per BUSY cycle: shift the {partial remainder, dividend} pair left by 1, subtract the divisor with 33-bit width, and set the quotient bit when the difference is non-negative.
REQ-015 SHALL execute exactly 32 BUSY cycles (N+1..N+32), then enter DONE at N+33.
REQ-016 SHALL, in DONE, drive ready=1 with result valid for exactly one cycle, then return to IDLE at N+34 regardless of start.
REQ-017 SHALL apply the sign fix-up for signed_div=1 when writing result: negate the quotient if the operand signs differ; give the remainder the sign of the dividend.
REQ-018 SHALL produce 0x80000000 / 0xFFFFFFFF (signed) as quotient 0x80000000, remainder 0, with no trap.
REQ-019 SHALL hold result unchanged outside DONE entry, so that the last value persists.
REQ-020 SHALL keep ready=0 in every state except DONE.
REQ-021 SHALL, when annul=1 in any state, enter IDLE next cycle with ready=0 and result unchanged; annul overrides start in the same cycle.
REQ-022 SHALL ignore start while in BUSY or DONE; operand changes while busy have no effect.
REQ-023 SHALL accept back-to-back operations: start=1 in the cycle after DONE (state IDLE) begins a new divide.

Reset
REQ-024 SHALL, on resetn=0 at a clock edge, set state=IDLE, ready=0, result=0, counter=0, and clear internal operand registers.
REQ-025 SHALL abandon any operation in progress when reset is asserted mid-operation, with no ready pulse afterwards.
REQ-026 SHALL ignore start during any cycle in which resetn=0.

Configuration
REQ-027 SHALL support macro DIV_ZERO_FAST_EN: when defined, a divisor of 0 at start enters DZERO at N+1, then DONE at N+2 with result=64'h0 and a normal ready pulse.
REQ-028 SHALL, without DIV_ZERO_FAST_EN, run a divisor-0 request through the full 32-step path (unsigned result: quotient 0xFFFFFFFF, remainder = dividend; signed: fix-up per REQ-017 applied); the value is architecturally undefined, but the latency remains 33 cycles.

Verification
REQ-029 SHALL verify: DIVU 100/7, start at cycle 0 -> ready=1 at cycle 33 only; result = {32'd2, 32'd14}.
REQ-030 SHALL verify: DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-031 SHALL verify: DIV 0x80000000/0xFFFFFFFF -> result {32'h0, 32'h80000000}, ready at cycle 33.
REQ-032 SHALL verify: start at cycle 0, annul at cycle 10 -> IDLE at 11, no ready pulse through cycle 40, result keeps its prior value; a new start at 12 -> ready at 45.
REQ-033 SHALL verify: DIVU 5/0 -> with DIV_ZERO_FAST_EN, ready at cycle 2, result 0; without it, ready at 33, result {32'd5, 32'hFFFFFFFF}.
REQ-034 SHALL verify: resetn=0 at cycle 20 of a divide -> ready=0 and result=0 from cycle 21; no ready pulse until a new start.
